// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts a parallel word over a valid/ready handshake and
// shifts it MSB-first through a programmable, overlapping pattern matcher.
// It reports how many matches the word held and the send-order index of the
// bit that completed the first match.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is high only while idle. in_valid may be held high
// across words, and in_data must stay stable while in_valid is high and the
// word has not yet been taken.
module seq_scan_ctrl #(
  parameter int DW = 16,  // word width, bits serialized per word
  parameter int PW = 5,   // maximum pattern length
  parameter int LW = 3,   // width of the length field
  parameter int CW = 5    // width of count / position results
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pat,
  input  logic [LW-1:0] cfg_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          bit_out,
  output logic          hit,
  output logic          done,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] first_pos,
  output logic          found,
  output logic [1:0]    state_dbg
);

  localparam int            IW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [LW-1:0] LEN_MAX  = LW'(PW);
  localparam logic [PW-1:0] PAT_DEF  = PW'(5'b10110);
  localparam logic [LW-1:0] LEN_DEF  = LW'(5);
  localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          shift_en;
  logic          last_bit;
  logic          cfg_ok;

  logic [PW-1:0] pat_q;
  logic [LW-1:0] len_q;
  logic [DW-1:0] data_q;
  logic [PW-1:0] hist;
  logic [PW-1:0] hist_nxt;
  logic [LW-1:0] seen;
  logic [LW-1:0] seen_nxt;
  logic [IW-1:0] idx;
  logic [PW-1:0] len_mask;
  logic          match;

  // Mask that keeps the low n bits of a PW-bit value.
  function automatic logic [PW-1:0] mask_of(input logic [LW-1:0] n);
    logic [PW-1:0] m;
    m = '0;
    for (int k = 0; k < PW; k++) begin
      if (k < int'(n)) m[k] = 1'b1;
    end
    return m;
  endfunction

  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift_en  = 1'b0;
    last_bit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (idx == IDX_LAST) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status flags follow the state the FSM is entering, so they are clean flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_nxt == IDLE);
      busy     <= (state_nxt == SHIFT);
      done     <= (state_nxt == DONE);
    end
  end

  // A config write lands only while idle and only with a legal length; a
  // write on the accept edge therefore applies to the word being accepted.
  assign cfg_ok = (state == IDLE) && cfg_we && (cfg_len <= LEN_MAX);

  // Pattern and length registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= PAT_DEF;
      len_q <= LEN_DEF;
    end else if (cfg_ok) begin
      pat_q <= cfg_pat;
      len_q <= cfg_len;
    end
  end

  // History as it will look once the current bit is taken in at the LSB;
  // the match decision is made on this post-shift view.
  assign hist_nxt = {hist[PW-2:0], data_q[DW-1]};
  assign seen_nxt = (seen >= LEN_MAX) ? seen : seen + 1'b1;
  assign len_mask = mask_of(len_q);
  assign match    = (len_q != '0) && (seen_nxt >= len_q) &&
                    ((hist_nxt & len_mask) == (pat_q & len_mask));

  // Serializer, history, and result registers. History is never cleared on
  // a match, so overlapping occurrences are all counted; it is cleared on
  // every accept so matches cannot span words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      hist      <= '0;
      seen      <= '0;
      idx       <= '0;
      bit_out   <= 1'b0;
      hit       <= 1'b0;
      match_cnt <= '0;
      first_pos <= '0;
      found     <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (accept) begin
        data_q    <= in_data;
        hist      <= '0;
        seen      <= '0;
        idx       <= '0;
        match_cnt <= '0;
        first_pos <= '0;
        found     <= 1'b0;
      end else if (shift_en) begin
        data_q  <= {data_q[DW-2:0], 1'b0};
        hist    <= hist_nxt;
        seen    <= seen_nxt;
        bit_out <= data_q[DW-1];
        if (!last_bit) idx <= idx + 1'b1;
        if (match) begin
          hit       <= 1'b1;
          match_cnt <= match_cnt + 1'b1;
          if (!found) begin
            first_pos <= CW'(idx);
            found     <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Testbench for seq_scan_ctrl: directed words and config writes, a
// word-level reference model, a per-cycle compare process, and a queue of
// hand-computed per-word results checked at each done strobe.
module tb_seq_scan_ctrl;

  localparam int DW = 16;
  localparam int PW = 5;
  localparam int LW = 3;
  localparam int CW = 5;
  localparam int RW = 2 * CW + 1;

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [PW-1:0] cfg_pat;
  logic [LW-1:0] cfg_len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          busy;
  logic          bit_out;
  logic          hit;
  logic          done;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] first_pos;
  logic          found;
  logic [1:0]    state_dbg;

  int checks   = 0;
  int errors   = 0;
  int hit_seen = 0;
  logic [RW-1:0] exp_q[$];

  // Reference model state: m_t counts rising edges since the accept edge
  // (-1 while idle); m_mv bit i marks a match completed by send index i.
  int            m_t       = -1;
  logic [DW-1:0] m_word    = '0;
  logic [DW-1:0] m_mv      = '0;
  logic [PW-1:0] m_pat     = 5'b10110;
  int            m_len     = 5;
  bit            m_bit_rst = 1'b1;

  seq_scan_ctrl #(.DW(DW), .PW(PW), .LW(LW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .bit_out   (bit_out),
    .hit       (hit),
    .done      (done),
    .match_cnt (match_cnt),
    .first_pos (first_pos),
    .found     (found),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slide a len-bit window over the word in send order and compare it with
  // the pattern, first-in-time pattern bit being p[len-1].
  function automatic logic [DW-1:0] match_vec(input logic [DW-1:0] w,
                                              input logic [PW-1:0] p, input int len);
    logic [DW-1:0] v;
    bit ok;
    v = '0;
    for (int i = 0; i < DW; i++) begin
      if (len > 0 && i + 1 >= len) begin
        ok = 1'b1;
        for (int j = 0; j < len; j++) begin
          if (w[DW-1-(i-len+1+j)] != p[len-1-j]) ok = 1'b0;
        end
        v[i] = ok;
      end
    end
    return v;
  endfunction

  function automatic logic [RW-1:0] res(input int cnt, input int pos, input bit f);
    return {CW'(cnt), CW'(pos), f};
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or negedge rst) begin
    logic [PW-1:0] p;
    int l;
    if (!rst) begin
      m_t       <= -1;
      m_mv      <= '0;
      m_pat     <= 5'b10110;
      m_len     <= 5;
      m_bit_rst <= 1'b1;
    end else if (m_t < 0) begin
      p = m_pat;
      l = m_len;
      if (cfg_we && int'(cfg_len) <= PW) begin
        p = cfg_pat;
        l = int'(cfg_len);
      end
      m_pat <= p;
      m_len <= l;
      if (in_valid) begin
        m_word    <= in_data;
        m_mv      <= match_vec(in_data, p, l);
        m_t       <= 0;
        m_bit_rst <= 1'b0;
      end
    end else if (m_t == DW) begin
      m_t <= -1;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int k;
    int cnt;
    int fp;
    bit any;
    logic [RW-1:0] e;
    k   = (m_t < 0) ? DW : m_t;
    cnt = 0;
    fp  = 0;
    any = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (i < k && m_mv[i]) begin
        cnt++;
        if (!any) begin
          fp  = i;
          any = 1'b1;
        end
      end
    end
    check("in_ready", 32'(in_ready), 32'(m_t < 0));
    check("busy", 32'(busy), 32'(m_t >= 0 && m_t < DW));
    check("done", 32'(done), 32'(m_t == DW));
    check("hit", 32'(hit), 32'((m_t >= 1 && m_t <= DW) ? m_mv[m_t-1] : 1'b0));
    check("match_cnt", 32'(match_cnt), 32'(cnt));
    check("first_pos", 32'(first_pos), 32'(fp));
    check("found", 32'(found), 32'(any));
    if (m_t >= 1 && m_t <= DW) check("bit_out", 32'(bit_out), 32'(m_word[DW-m_t]));
    else if (m_bit_rst)        check("bit_out_rst", 32'(bit_out), 32'(0));
    if (done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("done_result", 32'({match_cnt, first_pos, found}), 32'(e));
      end
    end
    if (hit) hit_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [PW-1:0] p, input logic [LW-1:0] l);
    cfg_we  = 1'b1;
    cfg_pat = p;
    cfg_len = l;
    step();
    cfg_we  = 1'b0;
  endtask

  // Returns just after the accept edge.
  task automatic send_word(input logic [DW-1:0] w, input bit hold);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 64) begin
      step();
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'(1));
    step();
    if (!hold) in_valid = 1'b0;
  endtask

  // lat counts rising edges from the accept edge through the one raising done;
  // start is how many of those edges have already passed.
  task automatic wait_done(input int start, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = start;
    while (!seen && lat < 64) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        step();
        lat++;
      end
    end
    if (!seen) check("done_timeout", 32'(seen), 32'(1));
    step();
  endtask

  task automatic run_word(input logic [DW-1:0] w, input logic [RW-1:0] e,
                          input int exp_hits, input string tag);
    int lat;
    exp_q.push_back(e);
    hit_seen = 0;
    send_word(w, 1'b0);
    wait_done(1, lat);
    check({tag, "_latency"}, 32'(lat), 32'(17));
    check({tag, "_hits"}, 32'(hit_seen), 32'(exp_hits));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst      = 1'b0;
    cfg_we   = 1'b0;
    cfg_pat  = '0;
    cfg_len  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_results", 32'({match_cnt, first_pos, found, hit, done, busy}), 32'(0));
    rst = 1'b1;
    step();

    // Pin the model with hand-derived match positions.
    check("model_b6c0", 32'(match_vec(16'hB6C0, 5'b10110, 5)), 32'(16'h0490));
    check("model_ffff", 32'(match_vec(16'hFFFF, 5'b00011, 2)), 32'(16'hFFFE));

    // Default pattern 10110/5: matches complete at bits 4, 7, 10.
    run_word(16'hB6C0, res(3, 4, 1'b1), 3, "b6c0");
    run_word(16'h0000, res(0, 0, 1'b0), 0, "zero");

    // Pattern "11": every bit from index 1 on completes a match.
    cfg_write(5'b00011, 3'd2);
    run_word(16'hFFFF, res(15, 1, 1'b1), 15, "ones");
    cfg_write(5'b00000, 3'd6);  // illegal length, ignored
    run_word(16'hFFFF, res(15, 1, 1'b1), 15, "len6_ignored");

    // Config write during SHIFT is ignored.
    cfg_write(5'b10110, 3'd5);
    exp_q.push_back(res(3, 4, 1'b1));
    send_word(16'hB6C0, 1'b0);
    repeat (3) step();
    cfg_write(5'b00101, 3'd3);
    wait_done(5, lat);
    check("cfg_in_shift_latency", 32'(lat), 32'(17));

    // Back-to-back with in_valid held: history must not carry over.
    exp_q.push_back(res(0, 0, 1'b0));
    exp_q.push_back(res(0, 0, 1'b0));
    hit_seen = 0;
    send_word(16'h000B, 1'b1);
    in_data = 16'h0000;
    wait_done(1, lat);
    check("b2b_ready", 32'(in_ready), 32'(1));
    step();
    check("b2b_accept", 32'(busy), 32'(1));
    in_valid = 1'b0;
    wait_done(1, lat);
    check("b2b_latency", 32'(lat), 32'(17));
    check("b2b_hits", 32'(hit_seen), 32'(0));

    // Reset in the middle of a scan, with a non-default config loaded.
    cfg_write(5'b00011, 3'd2);
    send_word(16'hB6C0, 1'b0);
    repeat (8) step();
    rst = 1'b0;
    step();
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_outputs", 32'({match_cnt, first_pos, found, hit, done, busy, bit_out}), 32'(0));
    repeat (2) step();
    rst = 1'b1;
    step();
    run_word(16'hB6C0, res(3, 4, 1'b1), 3, "after_reset");

    // Length 0, written on the same edge as the accept: no matches.
    cfg_we  = 1'b1;
    cfg_pat = 5'b10110;
    cfg_len = 3'd0;
    exp_q.push_back(res(0, 0, 1'b0));
    hit_seen = 0;
    send_word(16'hB6C0, 1'b0);
    cfg_we = 1'b0;
    wait_done(1, lat);
    check("len0_hits", 32'(hit_seen), 32'(0));

    // Full-length all-zero pattern: history saturation, matches from bit 4.
    cfg_write(5'b00000, 3'd5);
    run_word(16'h0000, res(12, 4, 1'b1), 12, "zeros5");
    cfg_write(5'b11111, 3'd7);  // illegal length, ignored
    run_word(16'h0000, res(12, 4, 1'b1), 12, "len7_ignored");

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
